// File: rtl/sky130_fd_io__lvc_b2b_pkg.sv
// Shared types and constants for the LVC b2b ground-clamp sequencer.
// The state encoding and the safe reset value for ogc_en live here.
package sky130_fd_io__lvc_b2b_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE,
    FAULT
  } state_t;

  localparam int MAX_DOM = 16;

  // All domains joined: the safe state.
  localparam logic [MAX_DOM-1:0] OGC_RST = '1;

endpackage

// File: rtl/sky130_fd_io__lvc_b2b_rr_arb.sv
// Combinational round-robin picker for pending domains.
// Search starts at last+1 and wraps around to last.
module sky130_fd_io__lvc_b2b_rr_arb #(
  parameter int NDOM = 4,
  parameter int IW   = $clog2(NDOM)
) (
  input  logic [NDOM-1:0] pend,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   sel,
  output logic            any_pend
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel      = '0;
    any_pend = |pend;
    for (int k = NDOM; k >= 1; k--) begin
      if (pend[(int'(last) + k) % NDOM]) begin
        sel = IW'((int'(last) + k) % NDOM);
      end
    end
  end

endmodule

// File: rtl/sky130_fd_io__lvc_b2b_seq.sv
// Join/isolate sequencer for the b2b ground clamps.
// One domain at a time: apply, settle, check, then ack or fault.
module sky130_fd_io__lvc_b2b_seq
  import sky130_fd_io__lvc_b2b_pkg::*;
#(
  parameter int NDOM        = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8,
  parameter int IW          = $clog2(NDOM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NDOM-1:0] req_join,
  input  logic [NDOM-1:0] dom_good,
  input  logic            clr_fault,
  output logic [NDOM-1:0] ogc_en,
  output logic [NDOM-1:0] ack,
  output logic            busy,
  output logic            fault,
  output logic [IW-1:0]   fault_dom
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_INIT    = CNT_W'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic              tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NDOM-1:0]   ogc_q, ogc_d;
  logic [IW-1:0]     last_q, last_d;
  logic              fault_q, fault_d;
  logic [IW-1:0]     fdom_q, fdom_d;

  logic [NDOM-1:0]   pend;
  logic [IW-1:0]     pick;
  logic              any_pend;

  assign pend = req_join ^ ogc_q;

  sky130_fd_io__lvc_b2b_rr_arb #(
    .NDOM (NDOM),
    .IW   (IW)
  ) u_arb (
    .pend     (pend),
    .last     (last_q),
    .sel      (pick),
    .any_pend (any_pend)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    ogc_d   = ogc_q;
    last_d  = last_q;
    fault_d = fault_q;
    fdom_d  = fdom_q;
    unique case (state_q)
      IDLE: begin
        if (any_pend && !fault_q) begin
          sel_d   = pick;
          tgt_d   = req_join[pick];
          state_d = APPLY;
        end
      end
      APPLY: begin
        ogc_d[sel_q] = tgt_q;
        cnt_d        = SETTLE_INIT;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = TMO_INIT;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (!tgt_q || dom_good[sel_q]) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          fault_d = 1'b1;
          fdom_d  = sel_q;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      FAULT: begin
        if (clr_fault) begin
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset rejoins every domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tgt_q   <= 1'b1;
      cnt_q   <= '0;
      ogc_q   <= OGC_RST[NDOM-1:0];
      last_q  <= IW'(NDOM - 1);
      fault_q <= 1'b0;
      fdom_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ogc_q   <= ogc_d;
      last_q  <= last_d;
      fault_q <= fault_d;
      fdom_q  <= fdom_d;
    end
  end

  // Ack is decoded from DONE so it drops at once on reset.
  always_comb begin
    ack = '0;
    if (state_q == DONE) begin
      ack[sel_q] = 1'b1;
    end
  end

  assign ogc_en    = ogc_q;
  assign busy      = (state_q != IDLE);
  assign fault     = fault_q;
  assign fault_dom = fdom_q;

endmodule
